// File: rtl/beat_judge_if.sv
// Bundle between the chart player / key pad (master) and the beat judge (slave).
// Carries the beat strobe, lane pattern, keys, pause and all judge results.
interface beat_judge_if #(
    parameter int DEPTH = 8
);
    logic                 oe;
    logic [7:0]           y;
    logic [7:0]           key;
    logic                 stop;
    logic [8*DEPTH-1:0]   field;
    logic [15:0]          score;
    logic [7:0]           combo;
    logic [7:0]           max_combo;
    logic                 hit;
    logic                 miss;
    logic                 done;

    modport master (
        output oe, y, key, stop,
        input  field, score, combo, max_combo, hit, miss, done
    );

    modport slave (
        input  oe, y, key, stop,
        output field, score, combo, max_combo, hit, miss, done
    );
endinterface

// File: rtl/beat_judge.sv
// Rhythm game judge: scrolls a DEPTH x 8 note field on each beat, judges key
// presses against the bottom two rows and keeps score, combo and end-of-song state.
module beat_judge #(
    parameter int DEPTH      = 8,
    parameter int SONG_BEATS = 100
) (
    input  logic          clk_i,
    input  logic          start_i,
    beat_judge_if.slave   bus
);
    localparam logic [1:0] PLAY  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam int         CW    = $clog2(SONG_BEATS + 1);
    localparam int         JROW  = 8 * (DEPTH - 1);
    localparam int         GROW  = 8 * (DEPTH - 2);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      beatCnt_q, beatCnt_d;
    logic [7:0]         keyPrev_q;
    logic [8*DEPTH-1:0] field_q, field_d, fieldJudged;
    logic [15:0]        score_q, score_d;
    logic [7:0]         combo_q, combo_d;
    logic [7:0]         maxCombo_q, maxCombo_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               done_q, done_d;

    logic               active;
    logic               beat;
    logic [7:0]         press, perfect, good, stray, missed, entryRow;
    logic [3:0]         perfCnt, goodCnt;
    logic [4:0]         scoreInc;
    logic [16:0]        scoreSum;
    logic [8:0]         comboSum;

    // Judging works on the pre-shift field so a note hit on a beat edge is never a miss.
    always_comb begin
        active   = !bus.stop && (state_q != DONE);
        beat     = active && bus.oe;
        press    = active ? (bus.key & ~keyPrev_q) : 8'h00;
        perfect  = press & field_q[JROW +: 8];
        good     = press & ~field_q[JROW +: 8] & field_q[GROW +: 8];
        stray    = press & ~field_q[JROW +: 8] & ~field_q[GROW +: 8];

        fieldJudged             = field_q;
        fieldJudged[JROW +: 8]  = field_q[JROW +: 8] & ~perfect;
        fieldJudged[GROW +: 8]  = field_q[GROW +: 8] & ~good;

        entryRow = (state_q == PLAY) ? ~bus.y : 8'h00;
        missed   = beat ? fieldJudged[JROW +: 8] : 8'h00;
        field_d  = beat ? {fieldJudged[JROW-1:0], entryRow} : fieldJudged;

        perfCnt = 4'd0;
        goodCnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            perfCnt = perfCnt + 4'(perfect[i]);
            goodCnt = goodCnt + 4'(good[i]);
        end
        scoreInc = {perfCnt, 1'b0} + 5'(goodCnt);
        scoreSum = {1'b0, score_q} + 17'(scoreInc);
        comboSum = {1'b0, combo_q} + 9'(perfCnt) + 9'(goodCnt);

        score_d = scoreSum[16] ? 16'hFFFF : scoreSum[15:0];
        if ((|missed) || (|stray)) begin
            combo_d = 8'd0;
        end else begin
            combo_d = comboSum[8] ? 8'hFF : comboSum[7:0];
        end
        maxCombo_d = (combo_d > maxCombo_q) ? combo_d : maxCombo_q;
        hit_d      = |(perfect | good);
        miss_d     = |missed;
    end

    // Song progress: count beats in PLAY, flush remaining notes in DRAIN, then park in DONE.
    always_comb begin
        state_d   = state_q;
        beatCnt_d = beatCnt_q;
        case (state_q)
            PLAY: begin
                if (beat) begin
                    beatCnt_d = beatCnt_q + 1'b1;
                    if (beatCnt_d == CW'(SONG_BEATS)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!bus.stop && (field_d == '0)) begin
                    state_d = DONE;
                end
            end
            default: state_d = state_q;
        endcase
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or posedge start_i) begin
        if (start_i) begin
            state_q    <= PLAY;
            beatCnt_q  <= '0;
            keyPrev_q  <= 8'h00;
            field_q    <= '0;
            score_q    <= 16'd0;
            combo_q    <= 8'd0;
            maxCombo_q <= 8'd0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            keyPrev_q  <= bus.key;
            state_q    <= state_d;
            beatCnt_q  <= beatCnt_d;
            field_q    <= field_d;
            score_q    <= score_d;
            combo_q    <= combo_d;
            maxCombo_q <= maxCombo_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            done_q     <= done_d;
        end
    end

    assign bus.field     = field_q;
    assign bus.score     = score_q;
    assign bus.combo     = combo_q;
    assign bus.max_combo = maxCombo_q;
    assign bus.hit       = hit_q;
    assign bus.miss      = miss_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_beat_judge.sv
// Directed bench for beat_judge: hand-computed expectations for judging,
// scrolling, pause behaviour and end-of-song drain.
module tb_beat_judge;
    localparam int DEPTH      = 8;
    localparam int SONG_BEATS = 20;

    logic clk;
    logic start;
    int   checkCount;
    int   passCount;

    beat_judge_if #(.DEPTH(DEPTH)) bus ();

    beat_judge #(
        .DEPTH      (DEPTH),
        .SONG_BEATS (SONG_BEATS)
    ) dut (
        .clk_i   (clk),
        .start_i (start),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish (actual timeout, required finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock with the given beat/pattern/keys; outputs are sampled 1ns after the edge.
    task automatic applyStimulus(input logic oeV, input logic [7:0] yV, input logic [7:0] keyV);
        bus.oe  = oeV;
        bus.y   = yV;
        bus.key = keyV;
        @(posedge clk);
        #1;
        bus.oe  = 1'b0;
    endtask

    task automatic pulseStart();
        bus.oe   = 1'b0;
        bus.y    = 8'hFF;
        bus.key  = 8'h00;
        bus.stop = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    function automatic logic [7:0] rowOf(input int r);
        return bus.field[8*r +: 8];
    endfunction

    initial begin
        checkCount = 0;
        passCount  = 0;
        start      = 1'b0;
        bus.oe     = 1'b0;
        bus.y      = 8'hFF;
        bus.key    = 8'h00;
        bus.stop   = 1'b0;
        #3;

        // Reset state and a PERFECT on the judge line
        pulseStart();
        checkOutput("rst_field", bus.field, 64'h0);
        checkOutput("rst_score", 64'(bus.score), 64'd0);
        checkOutput("rst_combo", 64'(bus.combo), 64'd0);
        checkOutput("rst_max", 64'(bus.max_combo), 64'd0);
        checkOutput("rst_hit", 64'(bus.hit), 64'd0);
        checkOutput("rst_miss", 64'(bus.miss), 64'd0);
        checkOutput("rst_done", 64'(bus.done), 64'd0);
        applyStimulus(1'b1, 8'h7F, 8'h00);
        checkOutput("entry_row0", 64'(rowOf(0)), 64'h80);
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b1, 8'hFF, 8'h00);
        checkOutput("note_at_judge", bus.field, 64'h8000_0000_0000_0000);
        applyStimulus(1'b0, 8'hFF, 8'h80);
        checkOutput("perf_hit", 64'(bus.hit), 64'd1);
        checkOutput("perf_score", 64'(bus.score), 64'd2);
        checkOutput("perf_combo", 64'(bus.combo), 64'd1);
        checkOutput("perf_row7", 64'(rowOf(DEPTH-1)), 64'h00);
        applyStimulus(1'b0, 8'hFF, 8'h00);
        checkOutput("hit_pulse_end", 64'(bus.hit), 64'd0);

        // GOOD one row early, no miss on the following scroll
        pulseStart();
        applyStimulus(1'b1, 8'h7F, 8'h00);
        for (int i = 0; i < DEPTH - 2; i++) applyStimulus(1'b1, 8'hFF, 8'h00);
        checkOutput("note_row6", 64'(rowOf(DEPTH-2)), 64'h80);
        applyStimulus(1'b0, 8'hFF, 8'h80);
        checkOutput("good_hit", 64'(bus.hit), 64'd1);
        checkOutput("good_score", 64'(bus.score), 64'd1);
        checkOutput("good_combo", 64'(bus.combo), 64'd1);
        applyStimulus(1'b0, 8'hFF, 8'h00);
        applyStimulus(1'b1, 8'hFF, 8'h00);
        checkOutput("good_nomiss", 64'(bus.miss), 64'd0);
        checkOutput("good_field", bus.field, 64'h0);

        // Combo of three, then a missed note
        pulseStart();
        applyStimulus(1'b1, 8'h7F, 8'h00);
        applyStimulus(1'b1, 8'h7F, 8'h00);
        applyStimulus(1'b1, 8'h7F, 8'h00);
        applyStimulus(1'b1, 8'hFE, 8'h00);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hFF, 8'h00);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 8'hFF, 8'h80);
            applyStimulus(1'b0, 8'hFF, 8'h00);
            applyStimulus(1'b1, 8'hFF, 8'h00);
        end
        checkOutput("combo3", 64'(bus.combo), 64'd3);
        checkOutput("combo3_max", 64'(bus.max_combo), 64'd3);
        checkOutput("combo3_nomiss", 64'(bus.miss), 64'd0);
        checkOutput("combo3_score", 64'(bus.score), 64'd6);
        applyStimulus(1'b1, 8'hFF, 8'h00);
        checkOutput("miss_pulse", 64'(bus.miss), 64'd1);
        checkOutput("miss_combo", 64'(bus.combo), 64'd0);
        checkOutput("miss_max", 64'(bus.max_combo), 64'd3);
        applyStimulus(1'b0, 8'hFF, 8'h00);
        checkOutput("miss_pulse_end", 64'(bus.miss), 64'd0);

        // Two-lane chord hit on the beat edge, then a stray press
        pulseStart();
        applyStimulus(1'b1, 8'h7B, 8'h00);
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b1, 8'hFF, 8'h00);
        checkOutput("chord_row7", 64'(rowOf(DEPTH-1)), 64'h84);
        applyStimulus(1'b1, 8'hFF, 8'h84);
        checkOutput("chord_score", 64'(bus.score), 64'd4);
        checkOutput("chord_combo", 64'(bus.combo), 64'd2);
        checkOutput("chord_hit", 64'(bus.hit), 64'd1);
        checkOutput("chord_nomiss", 64'(bus.miss), 64'd0);
        checkOutput("chord_field", bus.field, 64'h0);
        applyStimulus(1'b0, 8'hFF, 8'h01);
        checkOutput("stray_combo", 64'(bus.combo), 64'd0);
        checkOutput("stray_score", 64'(bus.score), 64'd4);
        checkOutput("stray_hit", 64'(bus.hit), 64'd0);
        checkOutput("stray_max", 64'(bus.max_combo), 64'd2);

        // Pause freezes the field; a key held across resume is not a press
        pulseStart();
        applyStimulus(1'b1, 8'h7F, 8'h00);
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b1, 8'hFF, 8'h00);
        applyStimulus(1'b0, 8'hFF, 8'h80);
        applyStimulus(1'b0, 8'hFF, 8'h00);
        applyStimulus(1'b1, 8'h7F, 8'h00);
        bus.stop = 1'b1;
        applyStimulus(1'b1, 8'hFE, 8'h01);
        applyStimulus(1'b0, 8'hFF, 8'h00);
        applyStimulus(1'b0, 8'hFF, 8'h01);
        checkOutput("stop_field", bus.field, 64'h80);
        checkOutput("stop_score", 64'(bus.score), 64'd2);
        checkOutput("stop_combo", 64'(bus.combo), 64'd1);
        checkOutput("stop_hit", 64'(bus.hit), 64'd0);
        bus.stop = 1'b0;
        applyStimulus(1'b0, 8'hFF, 8'h01);
        checkOutput("resume_combo", 64'(bus.combo), 64'd1);
        checkOutput("resume_score", 64'(bus.score), 64'd2);

        // End of song: last three beats carry notes, then drain to DONE
        pulseStart();
        for (int i = 0; i < SONG_BEATS - 3; i++) applyStimulus(1'b1, 8'hFF, 8'h00);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h7F, 8'h00);
        checkOutput("last_beat_field", bus.field, 64'h80_80_80);
        checkOutput("last_beat_done", 64'(bus.done), 64'd0);
        applyStimulus(1'b1, 8'h7F, 8'h00);
        checkOutput("drain_row0", bus.field, 64'h80_80_80_00);
        for (int i = 0; i < DEPTH - 2; i++) applyStimulus(1'b1, 8'h7F, 8'h00);
        checkOutput("drain_row7", bus.field, 64'h8000_0000_0000_0000);
        checkOutput("drain_not_done", 64'(bus.done), 64'd0);
        applyStimulus(1'b1, 8'h7F, 8'h00);
        checkOutput("done_level", 64'(bus.done), 64'd1);
        checkOutput("done_field", bus.field, 64'h0);
        applyStimulus(1'b1, 8'h7F, 8'h80);
        applyStimulus(1'b1, 8'h00, 8'h00);
        checkOutput("done_hold_field", bus.field, 64'h0);
        checkOutput("done_hold_score", 64'(bus.score), 64'd0);
        checkOutput("done_hold_hit", 64'(bus.hit), 64'd0);
        checkOutput("done_hold", 64'(bus.done), 64'd1);
        pulseStart();
        checkOutput("start_clears_done", 64'(bus.done), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
